// File: rtl/dest_sel_stage.sv
// Per-lane write-back destination select with $0 and intra-bundle WAW suppression, held in a
// one-entry valid/ready register (1-cycle latency); stalls when full and downstream not ready, flush empties.
module dest_sel_stage #(
  parameter int AWIDTH  = 5,
  parameter int LANES   = 2,
  parameter int RA_ADDR = 31
) (
  input  logic                      ds_i_clk,
  input  logic                      ds_i_rst_n,
  input  logic                      ds_i_valid,
  output logic                      ds_o_ready,
  input  logic                      ds_i_flush,
  input  logic [LANES-1:0]          ds_i_lane_en,
  input  logic [2*LANES-1:0]        ds_i_reg_dst,
  input  logic [LANES-1:0]          ds_i_reg_write,
  input  logic [AWIDTH*LANES-1:0]   ds_i_addr_rt,
  input  logic [AWIDTH*LANES-1:0]   ds_i_addr_rd,
  output logic                      ds_o_valid,
  input  logic                      ds_i_ready,
  output logic [AWIDTH*LANES-1:0]   ds_o_addr_dst,
  output logic [LANES-1:0]          ds_o_we,
  output logic [LANES-1:0]          ds_o_waw,
  output logic [15:0]               ds_o_bundle_cnt
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                    r_state;
  logic [AWIDTH*LANES-1:0]   r_addr;
  logic [LANES-1:0]          r_we;
  logic [LANES-1:0]          r_waw;
  logic [15:0]               r_cnt;

  logic [AWIDTH-1:0]         w_addr [LANES];
  logic [1:0]                w_mode [LANES];
  logic [AWIDTH*LANES-1:0]   w_addr_flat;
  logic [LANES-1:0]          w_we_raw;
  logic [LANES-1:0]          w_we;
  logic [LANES-1:0]          w_waw;
  logic                      w_load;
  logic                      w_drain;

  assign ds_o_valid      = (r_state == S_FULL);
  assign ds_o_ready      = !ds_o_valid || ds_i_ready;
  assign w_load          = ds_i_valid && ds_o_ready && !ds_i_flush;
  assign w_drain         = ds_o_valid && ds_i_ready && !ds_i_flush;
  assign ds_o_addr_dst   = r_addr;
  assign ds_o_we         = r_we;
  assign ds_o_waw        = r_waw;
  assign ds_o_bundle_cnt = r_cnt;

  always_comb begin
    w_addr_flat = '0;
    w_we_raw    = '0;
    w_we        = '0;
    w_waw       = '0;
    for (int k = 0; k < LANES; k++) begin
      w_mode[k] = ds_i_reg_dst[2*k +: 2];
      w_addr[k] = '0;
      if (ds_i_lane_en[k]) begin
        case (w_mode[k])
          2'b00:   w_addr[k] = ds_i_addr_rt[k*AWIDTH +: AWIDTH];
          2'b01:   w_addr[k] = ds_i_addr_rd[k*AWIDTH +: AWIDTH];
          2'b10:   w_addr[k] = RA_ADDR[AWIDTH-1:0];
          default: w_addr[k] = '0;
        endcase
      end
      w_we_raw[k] = ds_i_lane_en[k] && ds_i_reg_write[k] &&
                    (w_mode[k] != 2'b11) && (w_addr[k] != '0);
      w_addr_flat[k*AWIDTH +: AWIDTH] = w_addr[k];
    end
    // An older lane loses its write when any younger lane in the bundle targets the same register.
    for (int i = 0; i < LANES; i++) begin
      w_we[i] = w_we_raw[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (w_we_raw[j] && (w_addr[j] == w_addr[i])) w_we[i] = 1'b0;
      end
      w_waw[i] = w_we_raw[i] && !w_we[i];
    end
  end

  always_ff @(posedge ds_i_clk or negedge ds_i_rst_n) begin
    if (!ds_i_rst_n) begin
      r_state <= S_EMPTY;
      r_addr  <= '0;
      r_we    <= '0;
      r_waw   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_drain) r_cnt <= r_cnt + 16'd1;
      if (ds_i_flush) begin
        r_state <= S_EMPTY;
        r_addr  <= '0;
        r_we    <= '0;
        r_waw   <= '0;
      end else if (w_load) begin
        r_state <= S_FULL;
        r_addr  <= w_addr_flat;
        r_we    <= w_we;
        r_waw   <= w_waw;
      end else if (w_drain) begin
        r_state <= S_EMPTY;
        r_addr  <= '0;
        r_we    <= '0;
        r_waw   <= '0;
      end
    end
  end

endmodule
